// File: rtl/bmc_pkg.sv
// Shared constants and types for the biphase-mark frame transmitter.
package bmc_pkg;

  // Bits per subframe and the half-cells needed to send one subframe.
  localparam int SUBFRAME_BITS = 32;
  localparam int HALF_CELLS    = 2 * SUBFRAME_BITS;

  // Preamble half-cell patterns, leftmost half-cell sent first, written for
  // a line that was low just before the preamble.
  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  // Transmitter states: waiting for data or streaming a frame.
  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bmc_subframe_fmt.sv
// Builds one 32-bit subframe (payload, validity, user, status, parity) and
// selects the preamble pattern for a given channel and frame position.
// Bits 0-3 of the subframe word stand in for the preamble and are left at
// zero; the 8 preamble half-cells are delivered separately on 'preamble'.
module bmc_subframe_fmt
  import bmc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CH_W  = 1,
  parameter int FR_W  = 8
) (
  input  logic [WIDTH-1:0]         sample,
  input  logic [CH_W-1:0]          channel,
  input  logic [FR_W-1:0]          frame,
  input  logic                     validity,
  output logic [7:0]               preamble,
  output logic [SUBFRAME_BITS-1:0] subframe
);

  // Place the sample MSB-aligned in the payload field, add the flag bits and
  // close with an even-parity bit over bits 4..31; choose B/M/W preamble.
  always_comb begin
    subframe = '0;
    preamble = PRE_W;
    subframe[28-WIDTH +: WIDTH] = sample;
    subframe[28] = validity;
    subframe[29] = 1'b0;
    subframe[30] = 1'b0;
    subframe[31] = ^subframe[30:4];
    if (channel == '0) begin
      preamble = (frame == '0) ? PRE_B : PRE_M;
    end
  end

endmodule

// File: rtl/bmc_frame_tx.sv
// Biphase-mark frame transmitter: accepts one frame of CHANNELS samples at a
// time and serialises it as CHANNELS subframes of 64 half-cells each, one
// half-cell per clock. Frames are numbered 0..BLOCK_FRAMES-1 so that frame 0
// carries a B preamble and raises block_start.
module bmc_frame_tx
  import bmc_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int CHANNELS     = 2,
  parameter int BLOCK_FRAMES = 192
) (
  input  logic                      clock,
  input  logic                      nreset,
  input  logic                      enable,
  input  logic [CHANNELS*WIDTH-1:0] sample_data,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  output logic                      serial_out,
  output logic                      block_start,
  output logic                      underrun
);

  localparam int CH_W = index_width(CHANNELS);
  localparam int FR_W = index_width(BLOCK_FRAMES);

  localparam logic [CH_W-1:0] LAST_CH    = CH_W'(CHANNELS - 1);
  localparam logic [FR_W-1:0] LAST_FRAME = FR_W'(BLOCK_FRAMES - 1);
  localparam logic [5:0]      LAST_POS   = 6'(HALF_CELLS - 1);

  state_t state;
  state_t state_next;

  // Position of the half-cell currently shown on serial_out.
  logic [5:0]      pos;
  logic [CH_W-1:0] ch;
  logic [FR_W-1:0] frame;

  // Line level just before the current preamble; decides its polarity.
  logic pre_ref;

  // Frame being transmitted; zeroed with validity set on an underrun.
  logic [CHANNELS*WIDTH-1:0] frame_data;
  logic                      frame_invalid;

  logic            last_half;
  logic            frame_end;
  logic            transfer;
  logic            start_frame;
  logic [FR_W-1:0] frame_inc;
  logic [FR_W-1:0] start_idx;

  logic [5:0]               fmt_pos;
  logic [CH_W-1:0]          fmt_ch;
  logic [FR_W-1:0]          fmt_frame;
  logic [WIDTH-1:0]         fmt_sample;
  logic [7:0]               preamble;
  logic [SUBFRAME_BITS-1:0] subframe;
  logic                     next_line;

  assign last_half = (pos == LAST_POS);
  assign frame_end = (state == SEND) && last_half && (ch == LAST_CH);
  assign frame_inc = (frame == LAST_FRAME) ? '0 : frame + 1'b1;

  // Ready only at the closing half-cell of a frame or while idle, and never
  // when disabled or held in reset, so no accepted frame can be dropped.
  assign sample_ready = nreset && enable && ((state == IDLE) || frame_end);
  assign transfer     = sample_valid && sample_ready;

  // State register.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Decide whether a new frame starts next cycle and which index it uses;
  // from idle the held index is reused, at a boundary it advances.
  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    start_idx   = frame;
    case (state)
      IDLE: begin
        if (transfer) begin
          state_next  = SEND;
          start_frame = 1'b1;
        end
      end
      SEND: begin
        if (frame_end) begin
          if (enable) begin
            start_frame = 1'b1;
            start_idx   = frame_inc;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Work out the position of the half-cell that goes out on the next edge.
  always_comb begin
    fmt_pos   = pos + 1'b1;
    fmt_ch    = ch;
    fmt_frame = frame;
    if (start_frame) begin
      fmt_pos   = '0;
      fmt_ch    = '0;
      fmt_frame = start_idx;
    end else if (frame_end) begin
      fmt_pos = '0;
      fmt_ch  = '0;
    end else if (last_half) begin
      fmt_pos = '0;
      fmt_ch  = ch + 1'b1;
    end
  end

  assign fmt_sample = frame_data[fmt_ch*WIDTH +: WIDTH];

  bmc_subframe_fmt #(
    .WIDTH (WIDTH),
    .CH_W  (CH_W),
    .FR_W  (FR_W)
  ) u_fmt (
    .sample   (fmt_sample),
    .channel  (fmt_ch),
    .frame    (fmt_frame),
    .validity (frame_invalid),
    .preamble (preamble),
    .subframe (subframe)
  );

  // Next line level: preamble half-cells relative to the pre-preamble level,
  // otherwise a toggle at each bit start and a mid-bit toggle for a 1.
  // At a frame start only the preamble is consulted, so the not-yet-latched
  // payload of the incoming frame is never needed here.
  always_comb begin
    next_line = serial_out;
    if (fmt_pos < 6'd8) begin
      next_line = preamble[~fmt_pos[2:0]] ^ ((fmt_pos == 6'd0) ? serial_out : pre_ref);
    end else if (!fmt_pos[0]) begin
      next_line = ~serial_out;
    end else begin
      next_line = serial_out ^ subframe[fmt_pos[5:1]];
    end
  end

  // Counters, frame latch, line register and the one-cycle status pulses.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      pos           <= '0;
      ch            <= '0;
      frame         <= '0;
      pre_ref       <= 1'b0;
      serial_out    <= 1'b0;
      block_start   <= 1'b0;
      underrun      <= 1'b0;
      frame_data    <= '0;
      frame_invalid <= 1'b0;
    end else begin
      block_start <= 1'b0;
      underrun    <= 1'b0;
      if (start_frame) begin
        pos         <= '0;
        ch          <= '0;
        frame       <= start_idx;
        serial_out  <= next_line;
        pre_ref     <= serial_out;
        block_start <= (start_idx == '0);
        if (transfer) begin
          frame_data    <= sample_data;
          frame_invalid <= 1'b0;
        end else begin
          frame_data    <= '0;
          frame_invalid <= 1'b1;
          underrun      <= 1'b1;
        end
      end else if (frame_end) begin
        pos   <= '0;
        ch    <= '0;
        frame <= frame_inc;
      end else if (state == SEND) begin
        pos        <= fmt_pos;
        ch         <= fmt_ch;
        serial_out <= next_line;
        if (fmt_pos == 6'd0) begin
          pre_ref <= serial_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_bmc_frame_tx.sv
// Self-checking bench for bmc_frame_tx: a 16-bit stereo instance and a
// 24-bit four-channel instance, checked frame by frame against an encoder
// model that builds each subframe arithmetically and BMC-codes it.
module tb_bmc_frame_tx;

  logic clock = 1'b0;
  logic nreset;

  logic        enable1, valid1;
  logic [31:0] data1;
  logic        ready1, so1, bs1, ur1;

  logic        enable2, valid2;
  logic [95:0] data2;
  logic        ready2, so2, bs2, ur2;

  int compared   = 0;
  int mismatched = 0;

  // Model state: frame index expected next and line level after last frame.
  int mf1 = 0;
  int mf2 = 0;
  bit lvl1 = 1'b0;
  bit lvl2 = 1'b0;

  always #5 clock = ~clock;

  bmc_frame_tx #(.WIDTH(16), .CHANNELS(2), .BLOCK_FRAMES(192)) dut1 (
    .clock(clock), .nreset(nreset), .enable(enable1),
    .sample_data(data1), .sample_valid(valid1), .sample_ready(ready1),
    .serial_out(so1), .block_start(bs1), .underrun(ur1)
  );

  bmc_frame_tx #(.WIDTH(24), .CHANNELS(4), .BLOCK_FRAMES(4)) dut2 (
    .clock(clock), .nreset(nreset), .enable(enable2),
    .sample_data(data2), .sample_valid(valid2), .sample_ready(ready2),
    .serial_out(so2), .block_start(bs2), .underrun(ur2)
  );

  task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Expected half-cell sequence of one frame; element k is half-cell k.
  function automatic logic [255:0] modelFrame(input int nch, input int width,
                                              input logic [191:0] samples, input bit invalid,
                                              input int fidx, input bit lvl_in, output bit lvl_out);
    logic [255:0] v;
    logic [191:0] t;
    logic [31:0]  sf;
    logic [7:0]   pre;
    int           s, k;
    bit           lvl, lvl0;
    v = '0;
    k = 0;
    lvl = lvl_in;
    for (int c = 0; c < nch; c++) begin
      t  = samples >> (c * width);
      s  = invalid ? 0 : (int'(t[23:0]) & ((1 << width) - 1));
      sf = 32'(s) << (28 - width);
      sf[28] = invalid;
      sf[31] = ^sf[30:4];
      pre = (c != 0) ? 8'b11100100 : ((fidx == 0) ? 8'b11101000 : 8'b11100010);
      lvl0 = lvl;
      for (int i = 0; i < 8; i++) begin
        lvl = pre[7-i] ^ lvl0;
        v[k] = lvl;
        k++;
      end
      for (int b = 4; b < 32; b++) begin
        lvl = ~lvl;
        v[k] = lvl;
        k++;
        lvl = lvl ^ sf[b];
        v[k] = lvl;
        k++;
      end
    end
    lvl_out = lvl;
    return v;
  endfunction

  // Called at the negedge before a boundary edge: captures the whole frame,
  // drives the stimulus for the following boundary at its first half-cell,
  // and compares pulses, ready and the line against the model.
  task automatic applyStimulus(input bit sel, input string tag, input logic [191:0] samples,
                               input bit invalid, input bit nv, input logic [191:0] ndata,
                               input bit nen, output logic [255:0] obs);
    int n, nch, width, fidx, bf, stray;
    bit lvl, lvl_out;
    logic [255:0] expv;
    nch   = sel ? 4 : 2;
    width = sel ? 24 : 16;
    bf    = sel ? 4 : 192;
    n     = nch * 64;
    fidx  = sel ? mf2 : mf1;
    lvl   = sel ? lvl2 : lvl1;
    obs   = '0;
    stray = 0;
    @(posedge clock);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      obs[k] = sel ? so2 : so1;
      if (k == 0) begin
        checkOutput({tag, "_block_start"}, 256'(sel ? bs2 : bs1), 256'(fidx == 0));
        checkOutput({tag, "_underrun"}, 256'(sel ? ur2 : ur1), 256'(invalid));
        if (sel) begin
          valid2 = nv; data2 = ndata[95:0]; enable2 = nen;
        end else begin
          valid1 = nv; data1 = ndata[31:0]; enable1 = nen;
        end
      end else if ((sel ? bs2 : bs1) || (sel ? ur2 : ur1)) begin
        stray++;
      end
      if (k < n - 1 && (sel ? ready2 : ready1)) stray++;
    end
    checkOutput({tag, "_ready_last"}, 256'(sel ? ready2 : ready1), 256'(nen));
    checkOutput({tag, "_stray"}, 256'(stray), 256'(0));
    expv = modelFrame(nch, width, samples, invalid, fidx, lvl, lvl_out);
    checkOutput({tag, "_line"}, obs, expv);
    if (sel) begin
      lvl2 = lvl_out; mf2 = (fidx + 1) % bf;
    end else begin
      lvl1 = lvl_out; mf1 = (fidx + 1) % bf;
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [255:0] obs;
    logic [191:0] cur, nxt;
    logic [7:0]   pat;
    bit           nv, nen, cur_inv;
    int           bad;
    bit           ref_lvl;

    nreset = 1'b0;
    enable1 = 1'b0; valid1 = 1'b0; data1 = '0;
    enable2 = 1'b0; valid2 = 1'b0; data2 = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_outputs", 256'({ready1, so1, bs1, ur1, ready2, so2, bs2, ur2}), 256'(0));
    nreset = 1'b1;
    @(negedge clock);
    checkOutput("idle_ready_disabled", 256'(ready1), 256'(0));

    cur = {160'b0, 16'($urandom), 16'h0001};
    data1 = cur[31:0]; valid1 = 1'b1; enable1 = 1'b1;
    #1;
    checkOutput("idle_ready_enabled", 256'(ready1), 256'(1));
    nxt = {160'b0, 32'($urandom)};
    applyStimulus(0, "first", cur, 0, 1, nxt, 1, obs);
    for (int i = 0; i < 8; i++) pat[7-i] = obs[i];
    checkOutput("first_b_preamble", 256'(pat), 256'(8'b11101000));
    checkOutput("lsb_bit12_mid_toggle", 256'(obs[24] ^ obs[25]), 256'(1));
    checkOutput("bit13_no_mid_toggle", 256'(obs[26] ^ obs[27]), 256'(0));
    checkOutput("ch0_parity_one", 256'(obs[62] ^ obs[63]), 256'(1));
    cur = nxt; cur_inv = 1'b0;

    // Short stretch with one missed boundary, ending with enable dropped.
    for (int f = 1; f <= 5; f++) begin
      nv  = (f != 2);
      nen = (f != 5);
      nxt = {160'b0, 32'($urandom)};
      applyStimulus(0, $sformatf("f%0d", f), cur, cur_inv, nv, nxt, nen, obs);
      if (cur_inv) begin
        bad = 0;
        for (int c = 0; c < 2; c++) begin
          if (!(obs[c*64+56] ^ obs[c*64+57])) bad++;
          for (int b = 4; b < 28; b++) if (obs[c*64+2*b] ^ obs[c*64+2*b+1]) bad++;
        end
        checkOutput("underrun_zero_payload_validity", 256'(bad), 256'(0));
      end
      if (nv) cur = nxt;
      cur_inv = !nv;
    end

    bad = 0;
    repeat (20) begin
      @(negedge clock);
      if (so1 !== lvl1 || ready1 !== 1'b0) bad++;
    end
    checkOutput("idle_hold_line", 256'(bad), 256'(0));
    enable1 = 1'b1;
    #1;
    checkOutput("ready_follows_enable", 256'(ready1), 256'(1));

    // Long continuous stream with random underruns, crossing the block wrap.
    for (int f = 0; f < 190; f++) begin
      nv  = (f == 189) ? 1'b1 : ($urandom_range(0, 11) != 0);
      nxt = {160'b0, 32'($urandom)};
      applyStimulus(0, $sformatf("s%0d", f), cur, cur_inv, nv, nxt, 1, obs);
      if (nv) cur = nxt;
      cur_inv = !nv;
    end

    // Abort a frame at half-cell 70 with reset.
    repeat (71) @(negedge clock);
    #1 nreset = 1'b0;
    #1;
    checkOutput("reset_mid_frame", 256'({ready1, so1, bs1, ur1}), 256'(0));
    @(negedge clock);
    nreset = 1'b1;
    mf1 = 0; lvl1 = 1'b0; mf2 = 0; lvl2 = 1'b0;
    nxt = {160'b0, 32'($urandom)};
    applyStimulus(0, "after_reset", cur, 0, 1, nxt, 0, obs);
    for (int i = 0; i < 8; i++) pat[7-i] = obs[i];
    checkOutput("after_reset_b_preamble", 256'(pat), 256'(8'b11101000));

    // 24-bit, four-channel instance with full-scale samples.
    cur = {96'b0, {4{24'hFFFFFF}}};
    data2 = cur[95:0]; valid2 = 1'b1; enable2 = 1'b1;
    nxt = {96'b0, 32'($urandom), 32'($urandom), 32'($urandom)};
    applyStimulus(1, "w24_first", cur, 0, 1, nxt, 1, obs);
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      for (int b = 4; b < 28; b++) if (!(obs[c*64+2*b] ^ obs[c*64+2*b+1])) bad++;
    end
    checkOutput("w24_payload_all_ones", 256'(bad), 256'(0));
    bad = 0;
    for (int c = 0; c < 4; c++) if (obs[c*64+62] ^ obs[c*64+63]) bad++;
    checkOutput("w24_parity_zero", 256'(bad), 256'(0));
    for (int c = 0; c < 4; c++) begin
      ref_lvl = (c == 0) ? 1'b0 : obs[c*64-1];
      for (int i = 0; i < 8; i++) pat[7-i] = obs[c*64+i] ^ ref_lvl;
      checkOutput($sformatf("w24_preamble_ch%0d", c), 256'(pat),
                  256'((c == 0) ? 8'b11101000 : 8'b11100100));
    end
    cur = nxt; cur_inv = 1'b0;
    for (int f = 1; f <= 5; f++) begin
      nv  = (f == 5) ? 1'b1 : ($urandom_range(0, 3) != 0);
      nxt = {96'b0, 32'($urandom), 32'($urandom), 32'($urandom)};
      applyStimulus(1, $sformatf("w24_f%0d", f), cur, cur_inv, nv, nxt, (f != 5), obs);
      if (nv) cur = nxt;
      cur_inv = !nv;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
